// File: rtl/ifetch_pkg.sv
// Shared constants, helpers and types for the instruction fetch unit.
package ifetch_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 4;

    // Flush status: RUN while nothing is owed to the drop counter.
    localparam logic [0:0] FLUSH_RUN    = 1'b0;
    localparam logic [0:0] FLUSH_ACTIVE = 1'b1;

    // Pointers carry one extra wrap bit above the slot index.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // One slot-buffer entry at the default widths.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] data;
        logic                  filled;
    } slot_t;

endpackage

// File: rtl/ifetch_slot_buf.sv
// In-order slot buffer: entries are allocated on request, filled on response
// and popped by decode. Three wrap-bit pointers track the three positions.
module ifetch_slot_buf
    import ifetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc,
    input  logic [ADDR_W-1:0] alloc_pc,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              pop,
    input  logic              flush,
    output logic              space,
    output logic              pending,
    output logic [PTR_W-1:0]  outstanding,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_data
);

    localparam int unsigned IDX_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
        logic              filled;
    } entry_t;

    entry_t [DEPTH-1:0] slots_q;

    logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W-1:0] fill_ptr_q, fill_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] level;

    logic [IDX_W-1:0] alloc_idx, fill_idx, rd_idx;

    assign alloc_idx = alloc_ptr_q[IDX_W-1:0];
    assign fill_idx  = fill_ptr_q[IDX_W-1:0];
    assign rd_idx    = rd_ptr_q[IDX_W-1:0];

    // Occupancy and head view, all from registered pointers.
    always_comb begin
        level       = alloc_ptr_q - rd_ptr_q;
        space       = (level < DEPTH_P);
        pending     = (fill_ptr_q != alloc_ptr_q);
        outstanding = alloc_ptr_q - fill_ptr_q;
        head_valid  = (rd_ptr_q != fill_ptr_q) & slots_q[rd_idx].filled;
        head_pc     = slots_q[rd_idx].pc;
        head_data   = slots_q[rd_idx].data;
    end

    // Pointer next state; a flush wins over any same-cycle movement.
    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (flush) begin
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            rd_ptr_d    = '0;
        end else begin
            if (alloc) alloc_ptr_d = alloc_ptr_q + ONE;
            if (fill)  fill_ptr_d  = fill_ptr_q + ONE;
            if (pop)   rd_ptr_d    = rd_ptr_q + ONE;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            rd_ptr_q    <= '0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Slot storage; alloc and fill never target the same index in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            if (alloc) begin
                slots_q[alloc_idx].pc     <= alloc_pc;
                slots_q[alloc_idx].filled <= 1'b0;
            end
            if (fill) begin
                slots_q[fill_idx].data   <= fill_data;
                slots_q[fill_idx].filled <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues PC-stage addresses to instruction memory,
// buffers the in-order responses and flushes wrong-path work on redirect.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_ready,
    input  logic              redirect,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              resp_err
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] ONE = PTR_W'(1);

    logic             space;
    logic             pending;
    logic [PTR_W-1:0] outstanding;
    logic             head_valid;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_data;

    logic [PTR_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             resp_err_q, resp_err_d;
    logic [0:0]       flush_state;

    logic rsp_drop, rsp_fill, rsp_unexp;
    logic pop;

    // Handshakes and response classification.
    always_comb begin
        flush_state = (drop_cnt_q != '0) ? FLUSH_ACTIVE : FLUSH_RUN;
        mem_req     = rst_n & pc_valid & space & ~redirect;
        pc_ready    = mem_req & mem_gnt;
        mem_addr    = pc_addr;
        rsp_drop    = mem_rvalid & (flush_state == FLUSH_ACTIVE);
        rsp_fill    = mem_rvalid & (flush_state == FLUSH_RUN) & pending;
        rsp_unexp   = mem_rvalid & (flush_state == FLUSH_RUN) & ~pending;
        inst_valid  = rst_n & head_valid;
        inst_data   = head_data;
        inst_pc     = head_pc;
        pop         = inst_valid & inst_ready;
        resp_err    = resp_err_q;
    end

    // Drop accounting: on redirect every granted but unreturned request is owed
    // a discard, net of any response consumed in that same cycle.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (rsp_drop) drop_cnt_d = drop_cnt_d - ONE;
        if (redirect) drop_cnt_d = drop_cnt_d + outstanding - PTR_W'(rsp_fill);
        resp_err_d = resp_err_q | rsp_unexp;
    end

    // Drop counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            resp_err_q <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            resp_err_q <= resp_err_d;
        end
    end

    ifetch_slot_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_slot_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc       (pc_ready),
        .alloc_pc    (pc_addr),
        .fill        (rsp_fill),
        .fill_data   (mem_rdata),
        .pop         (pop),
        .flush       (redirect),
        .space       (space),
        .pending     (pending),
        .outstanding (outstanding),
        .head_valid  (head_valid),
        .head_pc     (head_pc),
        .head_data   (head_data)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a small in-order memory responder.
module tb_ifetch_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pc_valid;
    logic [AW-1:0] pc_addr;
    logic          pc_ready;
    logic          redirect;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          inst_valid;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_pc;
    logic          inst_ready;
    logic          resp_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mem_lat  = 1;
    bit mem_auto = 1'b1;

    logic [AW-1:0] q_addr[$];
    int            q_due[$];

    always #5 clk = ~clk;

    ifetch_unit #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_valid   (pc_valid),
        .pc_addr    (pc_addr),
        .pc_ready   (pc_ready),
        .redirect   (redirect),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .resp_err   (resp_err)
    );

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // One clock: sample grants mid-cycle, then advance the memory model.
    task automatic tick();
        logic          g;
        logic          r;
        logic [AW-1:0] ga;
        @(negedge clk);
        g  = pc_ready;
        ga = pc_addr;
        r  = rst_n;
        @(posedge clk);
        #1;
        cyc++;
        if (!r) begin
            q_addr.delete();
            q_due.delete();
        end else if (g) begin
            q_addr.push_back(ga);
            q_due.push_back(cyc + mem_lat - 1);
        end
        if (mem_auto) begin
            if (r && q_addr.size() > 0 && q_due[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = data_of(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc_valid = 1'b1; pc_addr = 32'd5; mem_gnt = 1'b1;
        inst_ready = 1'b1; redirect = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick(); #1;
        checks++; if (mem_req !== 1'b0) begin failures++;
            $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (pc_ready !== 1'b0) begin failures++;
            $display("FAIL reset_pc_ready: got %b want 0", pc_ready); end
        checks++; if (inst_valid !== 1'b0) begin failures++;
            $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        checks++; if (resp_err !== 1'b0) begin failures++;
            $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        rst_n = 1'b1; pc_valid = 1'b0;
        tick(); #1;
        checks++; if (inst_valid !== 1'b0) begin failures++;
            $display("FAIL post_reset_inst_valid: got %b want 0", inst_valid); end
        checks++; if (dut.drop_cnt_q !== 3'd0) begin failures++;
            $display("FAIL post_reset_drop: got %0d want 0", dut.drop_cnt_q); end
    endtask

    task automatic test_basic();
        int k = 0;
        int first = -1;
        mem_lat = 1; inst_ready = 1'b1; mem_gnt = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 4) begin pc_valid = 1'b1; pc_addr = 32'(c); end
            else pc_valid = 1'b0;
            #1;
            if (c < 4) begin
                checks++; if (pc_ready !== 1'b1 || mem_addr !== 32'(c)) begin failures++;
                    $display("FAIL basic_grant: c=%0d pc_ready=%b mem_addr=%0d want 1/%0d",
                             c, pc_ready, mem_addr, c); end
            end
            if (inst_valid) begin
                if (first < 0) first = c;
                checks++; if (inst_pc !== 32'(k) || inst_data !== data_of(32'(k))) begin
                    failures++;
                    $display("FAIL basic_order: got pc=%0d data=%h want pc=%0d data=%h",
                             inst_pc, inst_data, k, data_of(32'(k))); end
                k++;
            end
            tick();
        end
        checks++; if (first !== 2) begin failures++;
            $display("FAIL basic_latency: first valid at %0d want 2", first); end
        checks++; if (k !== 4) begin failures++;
            $display("FAIL basic_count: got %0d want 4", k); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int grants = 0;
        int pops = 0;
        int first_pop = -1;
        int fifth = -1;
        mem_lat = 1; inst_ready = 1'b0; mem_gnt = 1'b1;
        for (int c = 0; c < 10; c++) begin
            pc_valid = (n < 6); pc_addr = 32'(100 + n);
            #1;
            if (pc_ready) begin grants++; n++; end
            tick();
        end
        #1;
        checks++; if (grants !== 4) begin failures++;
            $display("FAIL bp_grants: got %0d want 4", grants); end
        checks++; if (mem_req !== 1'b0) begin failures++;
            $display("FAIL bp_full_req: got %b want 0", mem_req); end
        inst_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            pc_valid = (n < 6); pc_addr = 32'(100 + n);
            #1;
            if (inst_valid) begin
                if (first_pop < 0) first_pop = c;
                checks++; if (inst_pc !== 32'(100 + pops) || inst_data !== data_of(32'(100 + pops)))
                begin failures++;
                    $display("FAIL bp_order: got pc=%0d want %0d", inst_pc, 100 + pops); end
                pops++;
            end
            if (pc_ready) begin
                if (n == 4) fifth = c;
                n++;
            end
            tick();
        end
        inst_ready = 1'b0;
        checks++; if (pops !== 6) begin failures++;
            $display("FAIL bp_pops: got %0d want 6", pops); end
        checks++; if (first_pop < 0 || fifth !== first_pop + 1) begin failures++;
            $display("FAIL bp_fifth_req: at %0d want %0d", fifth, first_pop + 1); end
    endtask

    task automatic test_redirect();
        int  bad = 0;
        bit  got = 1'b0;
        logic g;
        mem_lat = 3; inst_ready = 1'b0; mem_gnt = 1'b1; redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_valid = 1'b1; pc_addr = 32'(10 + i);
            #1;
            checks++; if (pc_ready !== 1'b1) begin failures++;
                $display("FAIL redir_grant: addr %0d pc_ready=%b want 1", 10 + i, pc_ready); end
            tick();
        end
        // The response for 10 lands in the redirect cycle itself, so 2 are owed.
        redirect = 1'b1; pc_addr = 32'd40;
        #1;
        checks++; if (pc_ready !== 1'b0 || mem_req !== 1'b0) begin failures++;
            $display("FAIL redir_req_blocked: req=%b ready=%b want 0/0", mem_req, pc_ready); end
        tick();
        redirect = 1'b0;
        #1;
        checks++; if (dut.drop_cnt_q !== 3'd2) begin failures++;
            $display("FAIL redir_drop_cnt: got %0d want 2", dut.drop_cnt_q); end
        checks++; if (inst_valid !== 1'b0) begin failures++;
            $display("FAIL redir_flush_valid: got %b want 0", inst_valid); end
        for (int c = 0; c < 12; c++) begin
            if (inst_valid && inst_pc >= 32'd10 && inst_pc <= 32'd12) bad++;
            if (inst_valid && !got) begin
                got = 1'b1;
                checks++; if (inst_pc !== 32'd40 || inst_data !== data_of(32'd40)) begin
                    failures++;
                    $display("FAIL redir_target: got pc=%0d want 40", inst_pc); end
            end
            g = pc_ready;
            tick();
            if (g) pc_valid = 1'b0;
            #1;
        end
        checks++; if (got !== 1'b1 || bad !== 0) begin failures++;
            $display("FAIL redir_wrong_path: got40=%0d bad=%0d want 1/0", got, bad); end
        checks++; if (dut.drop_cnt_q !== 3'd0 || resp_err !== 1'b0) begin failures++;
            $display("FAIL redir_drained: drop=%0d err=%b want 0/0", dut.drop_cnt_q, resp_err); end
        inst_ready = 1'b1; tick(); inst_ready = 1'b0; #1;
        checks++; if (inst_valid !== 1'b0) begin failures++;
            $display("FAIL redir_empty: inst_valid=%b want 0", inst_valid); end
    endtask

    task automatic test_redirect_same_cycle();
        mem_lat = 1; inst_ready = 1'b0; mem_gnt = 1'b1;
        pc_valid = 1'b1; pc_addr = 32'd200;
        #1;
        checks++; if (pc_ready !== 1'b1) begin failures++;
            $display("FAIL rsc_grant: got %b want 1", pc_ready); end
        tick();
        redirect = 1'b1; pc_valid = 1'b0;
        #1;
        tick();
        redirect = 1'b0;
        #1;
        checks++; if (dut.drop_cnt_q !== 3'd0) begin failures++;
            $display("FAIL rsc_drop: got %0d want 0", dut.drop_cnt_q); end
        checks++; if (inst_valid !== 1'b0 || resp_err !== 1'b0) begin failures++;
            $display("FAIL rsc_empty: valid=%b err=%b want 0/0", inst_valid, resp_err); end
        tick(); #1;
        checks++; if (inst_valid !== 1'b0) begin failures++;
            $display("FAIL rsc_still_empty: got %b want 0", inst_valid); end
    endtask

    task automatic test_gnt_stall();
        mem_lat = 1; inst_ready = 1'b0; mem_gnt = 1'b0;
        pc_valid = 1'b1; pc_addr = 32'd300;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if ({mem_req, pc_ready} !== 2'b10) begin failures++;
                $display("FAIL stall_c%0d: req=%b ready=%b want 1/0", c, mem_req, pc_ready); end
            tick();
        end
        mem_gnt = 1'b1;
        #1;
        checks++; if (pc_ready !== 1'b1 || mem_addr !== 32'd300) begin failures++;
            $display("FAIL stall_release: ready=%b addr=%0d want 1/300", pc_ready, mem_addr); end
        tick();
        pc_valid = 1'b0;
        #1;
        for (int c = 0; c < 5 && !inst_valid; c++) begin
            tick(); #1;
        end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd300) begin failures++;
            $display("FAIL stall_result: valid=%b pc=%0d want 1/300", inst_valid, inst_pc); end
    endtask

    task automatic test_unexpected();
        mem_auto = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_rvalid = 1'b0;
        #1;
        checks++; if (resp_err !== 1'b1) begin failures++;
            $display("FAIL unexp_err: got %b want 1", resp_err); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd300 || inst_data !== data_of(32'd300))
        begin failures++;
            $display("FAIL unexp_buffer: valid=%b pc=%0d data=%h want 1/300/%h",
                     inst_valid, inst_pc, inst_data, data_of(32'd300)); end
        tick(); #1;
        checks++; if (resp_err !== 1'b1) begin failures++;
            $display("FAIL unexp_sticky: got %b want 1", resp_err); end
        mem_auto = 1'b1;
    endtask

    task automatic test_reset_mid();
        mem_lat = 1; inst_ready = 1'b0; mem_gnt = 1'b1;
        pc_valid = 1'b1; pc_addr = 32'd400;
        #1;
        checks++; if (pc_ready !== 1'b1) begin failures++;
            $display("FAIL mid_grant: got %b want 1", pc_ready); end
        tick();
        pc_valid = 1'b0;
        tick(); tick(); #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'd300) begin failures++;
            $display("FAIL mid_pre: valid=%b pc=%0d want 1/300", inst_valid, inst_pc); end
        rst_n = 1'b0; pc_valid = 1'b1; pc_addr = 32'd500;
        tick(); #1;
        checks++; if (inst_valid !== 1'b0 || resp_err !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: valid=%b err=%b req=%b want 0/0/0",
                     inst_valid, resp_err, mem_req); end
        rst_n = 1'b1; pc_valid = 1'b0;
        tick(); #1;
        checks++; if (inst_valid !== 1'b0) begin failures++;
            $display("FAIL mid_after: valid=%b want 0", inst_valid); end
        mem_auto = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_5A5A;
        tick();
        mem_rvalid = 1'b0;
        #1;
        checks++; if (resp_err !== 1'b1 || inst_valid !== 1'b0) begin failures++;
            $display("FAIL mid_stale: err=%b valid=%b want 1/0", resp_err, inst_valid); end
        mem_auto = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect();
        test_redirect_same_cycle();
        test_gnt_stall();
        test_unexpected();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
